share_recombiner: RTL

Unmasking endpoint for 2-share Boolean-masked datapaths: accepts a pair of output shares from a masked gadget pipeline over a valid/ready handshake and recombines them into plaintext. Each share is held in its own register and sits through a configurable settle window before the single XOR stage, so the shares never meet combinationally in the same cycle they are captured. All share and result registers are zeroized after use. The block sits at the boundary between the masked core and unmasked consumers, and is the target for VERICA/FORTIFY recombination-leakage experiments.

---
 rtl/masking_pkg.sv | 18 +
 rtl/share_reg.sv | 35 +++
 rtl/share_recombiner.sv | 113 +++++++++++
 3 files changed

// File: rtl/masking_pkg.sv
// masking_pkg: shared definitions for the masked-datapath boundary blocks.
//   rcmb_state_t : share_recombiner FSM states
//   NumShares    : number of Boolean shares per masked word
//   ZeroizeBit   : value replicated into share/result registers on zeroization
package masking_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCombine,
        StHold
    } rcmb_state_t;

    localparam int unsigned NumShares = 2;

    localparam logic ZeroizeBit = 1'b0;

endpackage

// File: rtl/share_reg.sv
// share_reg: one WIDTH-bit share holding register with load and zeroize.
// Kept as its own module so every share is a separately named register.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (clears the register)
//   i_load : capture i_d
//   i_zero : clear the register (wins over i_load)
//   i_d    : share value to capture
//   o_q    : held share value
module share_reg
    import masking_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_zero,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n || i_zero) begin
            r_q <= {WIDTH{ZeroizeBit}};
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/share_recombiner.sv
// share_recombiner: unmasking endpoint for a 2-share Boolean-masked word.
// The share pair is captured into separate registers, held for SETTLE_CYCLES,
// then XORed once into the registered result, and the shares are zeroized on
// that same edge. The result is cleared again after the output handshake.
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid / in_ready : share pair handshake (in_ready high only in idle)
//   z_share0, z_share1  : input shares
//   out_valid/out_ready : result handshake
//   z_data              : recombined word, z_share0 ^ z_share1
//   busy                : FSM is not idle
module share_recombiner
    import masking_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z_share0,
    input  logic [WIDTH-1:0] z_share1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z_data,
    output logic             busy
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("share_recombiner: SETTLE_CYCLES must be at least 1");
    end

    localparam int unsigned CntW = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntInit = CntW'(SETTLE_CYCLES - 1);

    rcmb_state_t      r_state;
    logic [CntW-1:0]  r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_z_data;

    logic             w_load;
    logic             w_zero;
    logic [WIDTH-1:0] w_share_d [NumShares];
    logic [WIDTH-1:0] w_share_q [NumShares];

    // Load/zeroize are state decodes; share data never feeds control.
    assign w_load = (r_state == StIdle) && in_valid;
    assign w_zero = (r_state == StCombine);

    assign w_share_d[0] = z_share0;
    assign w_share_d[1] = z_share1;

    for (genvar g = 0; g < NumShares; g++) begin : g_share
        share_reg #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_load (w_load),
            .i_zero (w_zero),
            .i_d    (w_share_d[g]),
            .o_q    (w_share_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_z_data    <= {WIDTH{ZeroizeBit}};
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_cnt   <= CntInit;
                        r_state <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_cnt == '0) begin
                        r_state <= StCombine;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StCombine: begin
                    // The only point where the two shares meet.
                    r_z_data    <= w_share_q[0] ^ w_share_q[1];
                    r_out_valid <= 1'b1;
                    r_state     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_z_data    <= {WIDTH{ZeroizeBit}};
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign busy      = (r_state != StIdle);
    assign out_valid = r_out_valid;
    assign z_data    = r_z_data;

endmodule
